// File: rtl/song_reader.sv
// Note sequencer: walks the {note,duration} words of one song in the song ROM and hands them to the note player.
// Optional build macro SONG_READER_REPEAT_EN: loop the current song instead of pulsing song_done at its end.
module song_reader #(
  parameter int ADDR_BITS = 5,
  parameter int NOTE_BITS = 6,
  parameter int DUR_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          reset_play,
  input  logic [1:0]                    song,
  input  logic                          note_done,
  output logic [ADDR_BITS+1:0]          rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
  output logic [NOTE_BITS-1:0]          note,
  output logic [DUR_BITS-1:0]           duration,
  output logic                          new_note,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    PLAY,
    DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_INDEX = '1;

  state_t                        state;
  state_t                        state_next;
  logic [ADDR_BITS-1:0]          note_index;
  logic [ADDR_BITS-1:0]          index_next;
  logic [1:0]                    fetch_song;
  logic [NOTE_BITS+DUR_BITS-1:0] rom_word;
  logic                          restart;
  logic                          start_fetch;
  logic                          capture;
  logic                          issue;
  logic                          finish;

  // In IDLE the index is already 0 and the next fetch latches the new song, so a song change there needs no restart.
  assign restart = reset_play || ((state != IDLE) && (song != fetch_song));

  always_comb begin
    state_next  = state;
    index_next  = note_index;
    start_fetch = 1'b0;
    capture     = 1'b0;
    issue       = 1'b0;
    finish      = 1'b0;
    if (restart) begin
      state_next = IDLE;
      index_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (play) begin
            state_next  = FETCH;
            start_fetch = 1'b1;
          end
        end
        FETCH: state_next = WAIT;
        WAIT: begin
          capture = 1'b1;
          if (rom_data[DUR_BITS-1:0] == '0) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          if (play) begin
            issue      = 1'b1;
            state_next = PLAY;
          end
        end
        PLAY: begin
          if (note_done) begin
            if (note_index == LAST_INDEX) begin
              state_next = DONE;
            end else begin
              index_next  = note_index + 1'b1;
              state_next  = FETCH;
              start_fetch = 1'b1;
            end
          end
        end
        DONE: begin
          index_next = '0;
`ifdef SONG_READER_REPEAT_EN
          state_next  = FETCH;
          start_fetch = 1'b1;
`else
          state_next = IDLE;
          finish     = 1'b1;
`endif
        end
        default: begin
          state_next = IDLE;
          index_next = '0;
        end
      endcase
    end
  end

  // rom_addr is loaded on entry to FETCH so the registered ROM answers during WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      note_index <= '0;
      fetch_song <= '0;
      rom_addr   <= '0;
      rom_word   <= '0;
      note       <= '0;
      duration   <= '0;
      new_note   <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_next;
      note_index <= index_next;
      new_note   <= issue;
      song_done  <= finish;
      if (start_fetch) begin
        rom_addr   <= {song, index_next};
        fetch_song <= song;
      end
      if (capture) begin
        rom_word <= rom_data;
      end
      if (issue) begin
        note     <= rom_word[DUR_BITS +: NOTE_BITS];
        duration <= rom_word[DUR_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: registered ROM model, directed timing steps and randomized songs
// compared against a note-list model derived from the ROM contents.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic        reset_play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom [0:127];
  logic [11:0] got[$];
  logic [11:0] exp_q[$];
  int          checks;
  int          errors;
  int          done_cnt;
  int          overlap;

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .reset_play (reset_play),
    .song       (song),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    play       = 1'b0;
    reset_play = 1'b1;
    @(negedge clk);
    reset_play = 1'b0;
  endtask

  task automatic fill_song(input int s, input int marker);
    for (int i = 0; i < 32; i++) begin
      rom[s*32+i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    end
    if (marker < 32) rom[s*32+marker][5:0] = 6'd0;
  endtask

  // Notes a song should produce: every word from index 0 up to the first zero duration.
  task automatic build_expected(input int s);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (rom[s*32+i][5:0] == 6'd0) break;
      exp_q.push_back(rom[s*32+i]);
    end
  endtask

  // Answers each new_note with a note_done after a random gap; stops on song_done or after max_notes notes.
  task automatic apply_stimulus(input int max_notes);
    int cycles;
    int countdown;
    bit stop;
    cycles    = 0;
    countdown = -1;
    stop      = 1'b0;
    while (!stop && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      note_done = 1'b0;
      if (new_note && song_done) overlap++;
      if (song_done) begin
        done_cnt++;
        stop = 1'b1;
      end else if (new_note) begin
        got.push_back({note, duration});
        if (got.size() >= max_notes) stop = 1'b1;
        else countdown = $urandom_range(0, 3);
      end
      if (!stop) begin
        if (countdown == 0) begin
          note_done = 1'b1;
          countdown = -1;
        end else if (countdown > 0) begin
          countdown--;
        end
      end
    end
    note_done = 1'b0;
    check_output("drive_finished", 32'(stop), 32'd1);
  endtask

  task automatic run_song(input int s);
    int start_done;
    int target;
    bit quiet;
    build_expected(s);
`ifdef SONG_READER_REPEAT_EN
    target = 2 * exp_q.size();
    exp_q  = {exp_q, exp_q};
`else
    target = 1000;
`endif
    got.delete();
    start_done = done_cnt;
    song = 2'(s);
    play = 1'b1;
    apply_stimulus(target);
    play = 1'b0;
    check_output("note_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check_output("note_word", 32'(got[i]), 32'(exp_q[i]));
    end
`ifdef SONG_READER_REPEAT_EN
    check_output("song_done_count", 32'(done_cnt - start_done), 32'd0);
`else
    check_output("song_done_count", 32'(done_cnt - start_done), 32'd1);
`endif
    @(negedge clk);
    check_output("song_done_width", 32'(song_done), 32'd0);
    quiet = 1'b0;
    repeat (4) begin
      @(negedge clk);
      quiet = quiet | new_note | song_done;
    end
    check_output("quiet_after_song", 32'(quiet), 32'd0);
    check_output("note_held", 32'({note, duration}), 32'(exp_q[exp_q.size()-1]));
`ifdef SONG_READER_REPEAT_EN
    reset_play = 1'b1;
    @(negedge clk);
    reset_play = 1'b0;
`endif
    play = 1'b1;
    @(negedge clk);
    check_output("restart_addr", 32'(rom_addr), 32'({2'(s), 5'd0}));
    go_idle();
  endtask

  initial begin
    bit quiet;
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    overlap    = 0;
    reset      = 1'b1;
    play       = 1'b1;
    reset_play = 1'b0;
    note_done  = 1'b0;
    song       = 2'd2;
    for (int s = 0; s < 4; s++) fill_song(s, 32);
    rom[64]       = {6'd12, 6'd4};
    rom[35][5:0]  = 6'd0;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    check_output("reset_rom_addr", 32'(rom_addr), 32'd0);
    check_output("reset_note", 32'(note), 32'd0);
    check_output("reset_duration", 32'(duration), 32'd0);
    check_output("reset_new_note", 32'(new_note), 32'd0);
    check_output("reset_song_done", 32'(song_done), 32'd0);
    reset = 1'b0;
    play  = 1'b0;
    step();

    $display("[TB] fetch latency, song 2");
    song = 2'd2;
    play = 1'b1;
    step();
    check_output("lat_rom_addr", 32'(rom_addr), 32'h40);
    check_output("lat_c0", 32'(new_note), 32'd0);
    step();
    check_output("lat_c1", 32'(new_note), 32'd0);
    step();
    check_output("lat_c2", 32'(new_note), 32'd0);
    step();
    check_output("lat_c3", 32'(new_note), 32'd1);
    check_output("lat_note", 32'(note), 32'd12);
    check_output("lat_duration", 32'(duration), 32'd4);
    step();
    check_output("lat_pulse_width", 32'(new_note), 32'd0);
    go_idle();
    check_output("hold_after_reset_play", 32'({note, duration}), 32'({6'd12, 6'd4}));

    $display("[TB] play low during fetch");
    play = 1'b1;
    step();
    play = 1'b0;
    quiet = 1'b0;
    repeat (5) begin
      step();
      quiet = quiet | new_note;
    end
    check_output("paused_no_new_note", 32'(quiet), 32'd0);
    play = 1'b1;
    step();
    check_output("resume_new_note", 32'(new_note), 32'd1);
    check_output("resume_note", 32'({note, duration}), 32'(rom[64]));
    go_idle();

    $display("[TB] end marker, song 1");
    run_song(1);
    $display("[TB] full song 3");
    run_song(3);

    $display("[TB] reset_play with note_done at index 5");
    got.delete();
    song = 2'd0;
    play = 1'b1;
    apply_stimulus(6);
    check_output("rp_index5_word", 32'(got[got.size()-1]), 32'(rom[5]));
    note_done  = 1'b1;
    reset_play = 1'b1;
    step();
    note_done  = 1'b0;
    reset_play = 1'b0;
    check_output("rp_no_song_done", 32'(song_done), 32'd0);
    check_output("rp_no_new_note", 32'(new_note), 32'd0);
    step();
    check_output("rp_fetch_addr", 32'(rom_addr), 32'h00);
    check_output("rp_no_song_done2", 32'(song_done), 32'd0);
    got.delete();
    apply_stimulus(1);
    check_output("rp_first_note", 32'(got[0]), 32'(rom[0]));
    go_idle();

    $display("[TB] song change 1 -> 3");
    got.delete();
    song = 2'd1;
    play = 1'b1;
    apply_stimulus(2);
    song = 2'd3;
    got.delete();
    apply_stimulus(1);
    check_output("chg_rom_addr", 32'(rom_addr), 32'h60);
    check_output("chg_first_note", 32'(got[0]), 32'(rom[96]));
    go_idle();

    $display("[TB] randomized songs");
    for (int k = 0; k < 4; k++) begin
      fill_song(0, $urandom_range(1, 36));
      run_song(0);
    end

    check_output("no_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
